// File: rtl/sound_sequencer.sv
// Collision-sound sequencer: plays a fixed, frame-timed note sequence per event code
// and returns a one-cycle finishCount pulse when the sequence (or a rejected code) ends.
//
// state | meaning
// IDLE  | waiting for enableSound, code latched on acceptance
// PLAY  | tone on, counting note frames
// GAP   | tone off between notes, counting silent frames
// DONE  | sequence over, raises finishCount
// COOL  | one cycle ignoring enableSound while the requester clears it
module sound_sequencer #(
  parameter int GAP_FRAMES = 1,
  parameter int DUR_SCALE  = 1
) (
  input  logic       clk_i,
  input  logic       resetN_i,
  input  logic       startOfFrame_i,
  input  logic       enableSound_i,
  input  logic [3:0] soundController_i,
  output logic [3:0] toneIndex_o,
  output logic       toneEn_o,
  output logic       busy_o,
  output logic       finishCount_o
);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_GAP, S_DONE, S_COOL} state_t;

  localparam logic [7:0] DUR_MUL = DUR_SCALE[7:0];
  localparam logic [7:0] GAP_CNT = GAP_FRAMES[7:0];

  // A zero duration marks a code with no sequence.
  function automatic logic [7:0] dur_of(input logic [3:0] code);
    case (code)
      4'd1:    return 8'd2;
      4'd2:    return 8'd4;
      4'd3:    return 8'd3;
      4'd4:    return 8'd6;
      4'd5:    return 8'd1;
      4'd6:    return 8'd8;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] len_of(input logic [3:0] code);
    case (code)
      4'd1, 4'd5: return 3'd1;
      4'd2:       return 3'd2;
      4'd3:       return 3'd3;
      4'd4, 4'd6: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] note_of(input logic [3:0] code, input logic [1:0] step);
    logic [3:0] n;
    n = 4'd0;
    case (code)
      4'd1: n = 4'd5;
      4'd2: n = (step == 2'd0) ? 4'd3 : 4'd1;
      4'd3: n = 4'd4 + {1'b0, step, 1'b0};
      4'd4: n = 4'd8 - {1'b0, step, 1'b0};
      4'd5: n = 4'd7;
      4'd6: begin
        case (step)
          2'd0:    n = 4'd0;
          2'd1:    n = 4'd2;
          2'd2:    n = 4'd4;
          default: n = 4'd7;
        endcase
      end
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic [1:0] step_q, step_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] tone_idx_q, tone_idx_d;
  logic       tone_en_q, tone_en_d;
  logic       busy_q, busy_d;
  logic       finish_q, finish_d;
  logic       last_note;

  assign last_note = ({1'b0, step_q} == (len_of(code_q) - 3'd1));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (enableSound_i) begin
          code_d = soundController_i;
          step_d = 2'd0;
          if (dur_of(soundController_i) != 8'd0) begin
            state_d = S_PLAY;
            cnt_d   = dur_of(soundController_i) * DUR_MUL;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PLAY: begin
        if (startOfFrame_i) begin
          if (cnt_q <= 8'd1) begin
            if (last_note) begin
              state_d = S_DONE;
            end else begin
              step_d = step_q + 2'd1;
              if (GAP_FRAMES == 0) begin
                cnt_d = dur_of(code_q) * DUR_MUL;
              end else begin
                state_d = S_GAP;
                cnt_d   = GAP_CNT;
              end
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_GAP: begin
        if (startOfFrame_i) begin
          if (cnt_q <= 8'd1) begin
            state_d = S_PLAY;
            cnt_d   = dur_of(code_q) * DUR_MUL;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_COOL;
      S_COOL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_comb begin
    tone_en_d  = (state_q == S_PLAY);
    tone_idx_d = (state_q == S_PLAY) ? note_of(code_q, step_q) : tone_idx_q;
    busy_d     = (state_q != S_IDLE);
    finish_d   = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!resetN_i) begin
      state_q    <= S_IDLE;
      code_q     <= 4'd0;
      step_q     <= 2'd0;
      cnt_q      <= 8'd0;
      tone_idx_q <= 4'd0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      tone_idx_q <= tone_idx_d;
      tone_en_q  <= tone_en_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
    end
  end

  assign toneIndex_o   = tone_idx_q;
  assign toneEn_o      = tone_en_q;
  assign busy_o        = busy_q;
  assign finishCount_o = finish_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: table-driven per-code runs, hand-written corner sequences,
// and a long random run against a timeline model for two parameter sets.
module tb_sound_sequencer;
  localparam int N = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN = 1'b0, sof = 1'b0, en = 1'b0;
  logic [3:0] sc = 4'd0;
  logic [3:0] idx0, idx1;
  logic       ten0, ten1, busy0, busy1, fin0, fin1;

  int checks = 0, errors = 0, cyc = 0;

  sound_sequencer #(.GAP_FRAMES(1), .DUR_SCALE(1)) u_dut (
    .clk_i(clk), .resetN_i(resetN), .startOfFrame_i(sof), .enableSound_i(en),
    .soundController_i(sc), .toneIndex_o(idx0), .toneEn_o(ten0), .busy_o(busy0),
    .finishCount_o(fin0));

  sound_sequencer #(.GAP_FRAMES(0), .DUR_SCALE(2)) u_dut2 (
    .clk_i(clk), .resetN_i(resetN), .startOfFrame_i(sof), .enableSound_i(en),
    .soundController_i(sc), .toneIndex_o(idx1), .toneEn_o(ten1), .busy_o(busy1),
    .finishCount_o(fin1));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sof = (cyc % 10 == 0);
  endtask

  // Event table: note count, frames per note, note list.
  function automatic int t_len(input int c);
    case (c)
      1, 5:    return 1;
      2:       return 2;
      3:       return 3;
      4, 6:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int t_dur(input int c);
    case (c)
      1: return 2;
      2: return 4;
      3: return 3;
      4: return 6;
      5: return 1;
      6: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int t_note(input int c, input int s);
    case (c)
      1: return 5;
      2: return (s == 0) ? 3 : 1;
      3: return 4 + 2 * s;
      4: return 8 - 2 * s;
      5: return 7;
      6: begin
        case (s)
          0: return 0;
          1: return 2;
          2: return 4;
          default: return 7;
        endcase
      end
      default: return 0;
    endcase
  endfunction

  // ---------------- directed runs ----------------
  typedef struct {
    int          code;
    int          n;
    logic [15:0] notes;
    int          frames;
  } vec_t;

  vec_t tbl[9];
  int r_n, r_fin, r_lat_tone, r_lat_fin, r_timeout;
  int r_notes[4];
  int r_cyc[4];

  task automatic run_code(input int code, input int swap_sc);
    int t0;
    logic prev_en;
    logic [3:0] prev_idx;
    r_n = 0; r_fin = 0; r_lat_tone = -1; r_lat_fin = -1; r_timeout = 1;
    for (int i = 0; i < 4; i++) begin r_notes[i] = -1; r_cyc[i] = 0; end
    en = 1'b1;
    sc = 4'(code);
    t0 = cyc;
    prev_en = 1'b0;
    prev_idx = 4'd0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (ten0 && (!prev_en || idx0 != prev_idx)) begin
        if (r_lat_tone < 0) r_lat_tone = cyc - t0;
        if (r_n < 4) r_notes[r_n] = int'(idx0);
        r_n++;
      end
      if (ten0 && r_n >= 1 && r_n <= 4) r_cyc[r_n-1]++;
      if (swap_sc >= 0 && r_n >= 2) sc = 4'(swap_sc);
      if (fin0) begin
        r_fin++;
        if (r_lat_fin < 0) r_lat_fin = cyc - t0;
        en = 1'b0;
      end
      prev_en = ten0;
      prev_idx = idx0;
      if (r_fin > 0 && !busy0) begin
        r_timeout = 0;
        break;
      end
    end
    chk($sformatf("code%0d_timeout", code), r_timeout, 0);
  endtask

  task automatic check_run(input vec_t v);
    chk($sformatf("code%0d_note_count", v.code), r_n, v.n);
    for (int i = 0; i < v.n && i < 4; i++) begin
      chk($sformatf("code%0d_note%0d", v.code, i), r_notes[i], int'(v.notes[4*i +: 4]));
      chk($sformatf("code%0d_frames%0d", v.code, i), (r_cyc[i] + 9) / 10, v.frames);
    end
    chk($sformatf("code%0d_finish_pulses", v.code), r_fin, 1);
    if (v.n == 0) chk($sformatf("code%0d_finish_latency", v.code), r_lat_fin, 2);
    else          chk($sformatf("code%0d_tone_latency", v.code), r_lat_tone, 2);
  endtask

  // ---------------- random-run timeline model ----------------
  bit         sof_a[N];
  bit         en_a[N];
  logic [3:0] sc_a[N];
  bit         xen[2][N];
  bit         xbusy[2][N];
  bit         xfin[2][N];
  logic [3:0] xidx[2][N];

  // Cycle of the n-th frame pulse at or after cycle 'from'.
  function automatic int nth_sof(input int from, input int n);
    int cnt = 0;
    for (int j = from; j < N; j++) begin
      if (sof_a[j]) begin
        cnt++;
        if (cnt == n) return j;
      end
    end
    return N + 5;
  endfunction

  // Outputs observed in cycle k reflect what the sequencer was doing in cycle k-1.
  task automatic build(input int d, input int gap, input int scale);
    int c, p, e, done, code;
    for (int k = 0; k < N; k++) begin
      xen[d][k] = 0; xbusy[d][k] = 0; xfin[d][k] = 0; xidx[d][k] = 4'd0;
    end
    c = 0;
    while (c < N) begin
      if (en_a[c]) begin
        code = int'(sc_a[c]);
        done = c + 1;
        if (t_len(code) > 0) begin
          p = c + 1;
          for (int s = 0; s < t_len(code); s++) begin
            e = nth_sof(p, t_dur(code) * scale);
            for (int k = p + 1; k <= e + 1 && k < N; k++) begin
              xen[d][k] = 1;
              xidx[d][k] = 4'(t_note(code, s));
            end
            if (s == t_len(code) - 1) done = e + 1;
            else if (gap > 0)         p = nth_sof(e + 1, gap) + 1;
            else                      p = e + 1;
          end
        end
        if (done + 1 < N) xfin[d][done+1] = 1;
        for (int k = c + 2; k <= done + 2 && k < N; k++) xbusy[d][k] = 1;
        c = done + 2;
      end else begin
        c++;
      end
    end
  endtask

  task automatic compare_cycle(input int k);
    chk("rnd0_toneEn", ten0, xen[0][k]);
    chk("rnd0_busy", busy0, xbusy[0][k]);
    chk("rnd0_finish", fin0, xfin[0][k]);
    if (xen[0][k]) chk("rnd0_toneIndex", idx0, xidx[0][k]);
    chk("rnd1_toneEn", ten1, xen[1][k]);
    chk("rnd1_busy", busy1, xbusy[1][k]);
    chk("rnd1_finish", fin1, xfin[1][k]);
    if (xen[1][k]) chk("rnd1_toneIndex", idx1, xidx[1][k]);
  endtask

  initial begin
    int f_cyc, r_cyc2, lows, fins2, tone_cycles, fins_after, busy_after, gap_ctr;
    logic prev;

    tbl[0] = '{1, 1, 16'h0005, 2};
    tbl[1] = '{2, 2, 16'h0013, 4};
    tbl[2] = '{3, 3, 16'h0864, 3};
    tbl[3] = '{4, 4, 16'h2468, 6};
    tbl[4] = '{5, 1, 16'h0007, 1};
    tbl[5] = '{6, 4, 16'h7420, 8};
    tbl[6] = '{0, 0, 16'h0000, 0};
    tbl[7] = '{9, 0, 16'h0000, 0};
    tbl[8] = '{15, 0, 16'h0000, 0};

    resetN = 1'b0;
    step();
    step();
    chk("reset_toneEn", ten0, 0);
    chk("reset_toneIndex", idx0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_finish", fin0, 0);
    resetN = 1'b1;

    for (int t = 0; t < 9; t++) begin
      run_code(tbl[t].code, -1);
      check_run(tbl[t]);
    end

    // Code change mid-sequence must not alter the running sequence.
    run_code(3, 1);
    check_run(tbl[2]);

    // enableSound held across finishCount: one idle cycle, then restart.
    en = 1'b1; sc = 4'd1;
    f_cyc = -1; r_cyc2 = -1; lows = 0; fins2 = 0; prev = 1'b0;
    for (int k = 0; k < 800; k++) begin
      step();
      if (fin0 && f_cyc < 0) f_cyc = cyc;
      else if (fin0 && r_cyc2 >= 0) fins2++;
      if (f_cyc >= 0 && r_cyc2 < 0 && !busy0) lows++;
      if (f_cyc >= 0 && r_cyc2 < 0 && ten0 && !prev) begin
        r_cyc2 = cyc;
        en = 1'b0;
      end
      prev = ten0;
      if (r_cyc2 >= 0 && fins2 > 0 && !busy0) break;
    end
    chk("hold_restart_delay", r_cyc2 - f_cyc, 3);
    chk("hold_busy_low_cycles", lows, 1);
    chk("hold_second_finish", fins2, 1);

    // Reset in the middle of a long note.
    en = 1'b1; sc = 4'd4; tone_cycles = 0;
    for (int k = 0; k < 200 && tone_cycles < 15; k++) begin
      step();
      if (ten0) tone_cycles++;
    end
    chk("midreset_reached_play", tone_cycles, 15);
    resetN = 1'b0; en = 1'b0;
    step();
    chk("midreset_toneEn", ten0, 0);
    chk("midreset_toneIndex", idx0, 0);
    chk("midreset_busy", busy0, 0);
    chk("midreset_finish", fin0, 0);
    resetN = 1'b1;
    fins_after = 0; busy_after = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (fin0) fins_after++;
      if (busy0) busy_after++;
    end
    chk("midreset_no_finish", fins_after, 0);
    chk("midreset_stays_idle", busy_after, 0);

    // Random stimulus: irregular frame pulses, bursty requests, changing codes.
    gap_ctr = 0;
    for (int k = 0; k < N; k++) begin
      if (gap_ctr == 0) begin
        sof_a[k] = 1;
        gap_ctr = $urandom_range(12, 2);
      end else begin
        sof_a[k] = 0;
        gap_ctr--;
      end
      en_a[k] = (k > 0 && k < N - 1000) ? ($urandom_range(2, 0) != 0) : 1'b0;
      if (k == 0 || $urandom_range(2, 0) == 0) begin
        sc_a[k] = 4'($urandom_range(9, 0));
        if (sc_a[k] == 4'd9) sc_a[k] = 4'd15;
      end else begin
        sc_a[k] = sc_a[k-1];
      end
    end
    build(0, 1, 1);
    build(1, 0, 2);

    resetN = 1'b0; en = 1'b0;
    step();
    step();
    resetN = 1'b1;
    sof = sof_a[0]; en = en_a[0]; sc = sc_a[0];
    compare_cycle(0);
    for (int k = 1; k < N; k++) begin
      step();
      sof = sof_a[k]; en = en_a[k]; sc = sc_a[k];
      compare_cycle(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
